// File: rtl/strobe_meter.sv
// Strobe period meter: measures enabled cycles between sampled strobes and hands each
// result out over a valid/ready pair. Defining STROBE_METER_MINMAX_EN adds min/max tracking.
module strobe_meter #(
   parameter int unsigned CTRL_PERIOD_W = 16,
   parameter int unsigned CTRL_COUNT_W  = 16
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic                     i_cg,
   input  logic                     i_strobe,
   input  logic                     i_clear,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [CTRL_PERIOD_W-1:0] o_periodM1,
   output logic [CTRL_PERIOD_W-1:0] o_minPeriodM1,
   output logic [CTRL_PERIOD_W-1:0] o_maxPeriodM1,
   output logic [CTRL_COUNT_W-1:0]  o_nStrobes,
   output logic                     o_overflow,
   output logic                     o_dropped
);

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t                   state_q, state_d;
   logic [CTRL_PERIOD_W-1:0] cnt_q;
   logic [CTRL_PERIOD_W-1:0] cnt_inc;
   logic [CTRL_PERIOD_W-1:0] period_q;
   logic [CTRL_COUNT_W-1:0]  n_strobes_q;
   logic                     valid_q;
   logic                     overflow_q;
   logic                     dropped_q;

   logic do_clear;
   logic take_strobe;
   logic capture;

   // Clear wins over a same-cycle strobe; nothing is sampled while the gate is low.
   assign do_clear    = i_cg & i_clear;
   assign take_strobe = i_cg & i_strobe & ~i_clear;
   assign cnt_inc     = cnt_q + 1'b1;

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      if (do_clear) begin
         state_d = IDLE;
      end else if (take_strobe) begin
         state_d = MEASURE;
         capture = (state_q == MEASURE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (do_clear) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (take_strobe) begin
         cnt_q <= '0;
      end else if (i_cg && (state_q == MEASURE) && !(&cnt_q)) begin
         cnt_q <= cnt_inc;
         if (&cnt_inc) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // A result arriving while the previous one is still unaccepted is lost, not queued.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         valid_q   <= 1'b0;
         period_q  <= '0;
         dropped_q <= 1'b0;
      end else if (do_clear) begin
         valid_q   <= 1'b0;
         period_q  <= '0;
         dropped_q <= 1'b0;
      end else if (i_cg) begin
         if (capture) begin
            if (valid_q && !i_ready) begin
               dropped_q <= 1'b1;
            end else begin
               period_q <= cnt_q;
               valid_q  <= 1'b1;
            end
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         n_strobes_q <= '0;
      end else if (do_clear) begin
         n_strobes_q <= '0;
      end else if (take_strobe && !(&n_strobes_q)) begin
         n_strobes_q <= n_strobes_q + 1'b1;
      end
   end

`ifdef STROBE_METER_MINMAX_EN
   logic [CTRL_PERIOD_W-1:0] min_q;
   logic [CTRL_PERIOD_W-1:0] max_q;

   // Extremes follow every captured value, including ones dropped at the output.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         min_q <= '1;
         max_q <= '0;
      end else if (do_clear) begin
         min_q <= '1;
         max_q <= '0;
      end else if (capture) begin
         if (cnt_q < min_q) begin
            min_q <= cnt_q;
         end
         if (cnt_q > max_q) begin
            max_q <= cnt_q;
         end
      end
   end

   assign o_minPeriodM1 = min_q;
   assign o_maxPeriodM1 = max_q;
`else
   assign o_minPeriodM1 = '1;
   assign o_maxPeriodM1 = '0;
`endif

   assign o_valid    = valid_q;
   assign o_periodM1 = period_q;
   assign o_nStrobes = n_strobes_q;
   assign o_overflow = overflow_q;
   assign o_dropped  = dropped_q;

endmodule

// File: tb/tb_strobe_meter.sv
// Directed bench for strobe_meter: a 16-bit instance for most scenarios and a 4-bit
// instance sharing the same stimulus for counter saturation.
module tb_strobe_meter;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic cg     = 1'b0;
   logic strobe = 1'b0;
   logic clear  = 1'b0;
   logic ready  = 1'b0;

   logic        valid;
   logic [15:0] period;
   logic [15:0] min_p;
   logic [15:0] max_p;
   logic [15:0] n_str;
   logic        ovf;
   logic        drop;

   logic        n_valid;
   logic [3:0]  n_period;
   logic [3:0]  n_min_p;
   logic [3:0]  n_max_p;
   logic [15:0] n_n_str;
   logic        n_ovf;
   logic        n_drop;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef STROBE_METER_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   strobe_meter #(.CTRL_PERIOD_W(16), .CTRL_COUNT_W(16)) dut (
      .i_clk         (clk),
      .i_arst_n      (rst_n),
      .i_cg          (cg),
      .i_strobe      (strobe),
      .i_clear       (clear),
      .i_ready       (ready),
      .o_valid       (valid),
      .o_periodM1    (period),
      .o_minPeriodM1 (min_p),
      .o_maxPeriodM1 (max_p),
      .o_nStrobes    (n_str),
      .o_overflow    (ovf),
      .o_dropped     (drop)
   );

   strobe_meter #(.CTRL_PERIOD_W(4), .CTRL_COUNT_W(16)) dut_narrow (
      .i_clk         (clk),
      .i_arst_n      (rst_n),
      .i_cg          (cg),
      .i_strobe      (strobe),
      .i_clear       (clear),
      .i_ready       (ready),
      .o_valid       (n_valid),
      .o_periodM1    (n_period),
      .o_minPeriodM1 (n_min_p),
      .o_maxPeriodM1 (n_max_p),
      .o_nStrobes    (n_n_str),
      .o_overflow    (n_ovf),
      .o_dropped     (n_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_min(input int v);
      return MINMAX ? 32'(v) : 32'h0000_ffff;
   endfunction

   function automatic logic [31:0] exp_max(input int v);
      return MINMAX ? 32'(v) : 32'h0;
   endfunction

   // One clock with the given strobe/clear; outputs are read 1 ns after the edge.
   task automatic step(input logic strb, input logic clr);
      strobe = strb;
      clear  = clr;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_valid"},    32'(valid),  32'd0);
      check({pfx, "_period"},   32'(period), 32'd0);
      check({pfx, "_min"},      32'(min_p),  32'h0000_ffff);
      check({pfx, "_max"},      32'(max_p),  32'd0);
      check({pfx, "_nstrobes"}, 32'(n_str),  32'd0);
      check({pfx, "_overflow"}, 32'(ovf),    32'd0);
      check({pfx, "_dropped"},  32'(drop),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gaps [3] = '{3, 5, 4};

      // Reset holds everything at reset values even with the gate and a strobe active.
      cg     = 1'b1;
      ready  = 1'b1;
      strobe = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      strobe = 1'b0;
      rst_n  = 1'b1;

      // Steady strobes every 5 cycles, consumer always ready.
      step(1'b1, 1'b0);
      check("steady_first_valid", 32'(valid), 32'd0);
      check("steady_first_count", 32'(n_str), 32'd1);
      for (int k = 0; k < 3; k++) begin
         gap(1);
         check($sformatf("steady_valid_low_%0d", k), 32'(valid), 32'd0);
         gap(3);
         step(1'b1, 1'b0);
         check($sformatf("steady_valid_%0d", k),  32'(valid),  32'd1);
         check($sformatf("steady_period_%0d", k), 32'(period), 32'd4);
         check($sformatf("steady_count_%0d", k),  32'(n_str),  32'(k + 2));
      end
      gap(1);
      check("steady_valid_drop", 32'(valid), 32'd0);
      check("steady_min", 32'(min_p), exp_min(4));
      check("steady_max", 32'(max_p), exp_max(4));
      check("steady_overflow", 32'(ovf), 32'd0);

      // Varying spacing 4, 6, 5 -> periods 3, 5, 4.
      step(1'b0, 1'b1);
      check_reset("clr");
      step(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         gap(gaps[k]);
         step(1'b1, 1'b0);
         check($sformatf("vary_period_%0d", k), 32'(period), 32'(gaps[k]));
      end
      check("vary_count", 32'(n_str), 32'd4);
      check("vary_min", 32'(min_p), exp_min(3));
      check("vary_max", 32'(max_p), exp_max(5));

      // Back-pressure: second result dropped, third accepted in the handshake cycle.
      step(1'b0, 1'b1);
      ready = 1'b0;
      step(1'b1, 1'b0);
      gap(2);
      step(1'b1, 1'b0);
      check("bp_first_valid",  32'(valid),  32'd1);
      check("bp_first_period", 32'(period), 32'd2);
      check("bp_first_drop",   32'(drop),   32'd0);
      gap(5);
      step(1'b1, 1'b0);
      check("bp_held_period", 32'(period), 32'd2);
      check("bp_held_valid",  32'(valid),  32'd1);
      check("bp_dropped",     32'(drop),   32'd1);
      gap(3);
      ready = 1'b1;
      step(1'b1, 1'b0);
      check("bp_third_period", 32'(period), 32'd3);
      check("bp_third_valid",  32'(valid),  32'd1);
      check("bp_drop_sticky",  32'(drop),   32'd1);
      gap(1);
      check("bp_valid_low", 32'(valid), 32'd0);
      check("bp_min", 32'(min_p), exp_min(2));
      check("bp_max", 32'(max_p), exp_max(5));

      // Reset mid-measurement discards the partial interval.
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(3);
      pulse_reset();
      check("midrst_valid",  32'(valid),  32'd0);
      check("midrst_period", 32'(period), 32'd0);
      gap(2);
      step(1'b1, 1'b0);
      check("midrst_first_valid", 32'(valid), 32'd0);
      check("midrst_first_count", 32'(n_str), 32'd1);
      gap(4);
      step(1'b1, 1'b0);
      check("midrst_meas_valid",  32'(valid),  32'd1);
      check("midrst_meas_period", 32'(period), 32'd4);

      // 4-bit counter saturates over a 20-cycle gap; 16-bit copy measures it exactly.
      pulse_reset();
      step(1'b1, 1'b0);
      gap(14);
      check("narrow_no_ovf_yet", 32'(n_ovf), 32'd0);
      gap(6);
      step(1'b1, 1'b0);
      check("narrow_period",   32'(n_period), 32'd15);
      check("narrow_overflow", 32'(n_ovf),    32'd1);
      check("narrow_valid",    32'(n_valid),  32'd1);
      check("wide_period",     32'(period),   32'd20);
      check("wide_overflow",   32'(ovf),      32'd0);

      // Clear in the same cycle as a strobe mid-measurement.
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(2);
      step(1'b1, 1'b0);
      check("clrstb_pre_period", 32'(period), 32'd2);
      gap(2);
      step(1'b1, 1'b1);
      check_reset("clrstb");
      gap(2);
      step(1'b1, 1'b0);
      check("clrstb_idle_valid", 32'(valid), 32'd0);
      check("clrstb_idle_count", 32'(n_str), 32'd1);
      gap(4);
      step(1'b1, 1'b0);
      check("clrstb_meas_period", 32'(period), 32'd4);

      // Gated cycles inside an interval, with a strobe pulsed while gated.
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      gap(2);
      cg = 1'b0;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      cg = 1'b1;
      gap(2);
      step(1'b1, 1'b0);
      check("gate_period", 32'(period), 32'd4);
      check("gate_count",  32'(n_str),  32'd2);
      check("gate_valid",  32'(valid),  32'd1);
      cg = 1'b0;
      gap(2);
      check("gate_ready_ignored", 32'(valid), 32'd1);
      step(1'b0, 1'b1);
      check("gate_clear_ignored", 32'(n_str), 32'd2);
      cg = 1'b1;
      gap(1);
      check("gate_valid_release", 32'(valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/strobe_meter.md
STROBE_METER -- requirements
Module: strobe_meter

Interface
REQ-001 SHALL have parameter CTRL_PERIOD_W, default 16, width of measured period and min/max fields.
REQ-002 SHALL have parameter CTRL_COUNT_W, default 16, width of strobe counter.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_arst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-005 SHALL have port i_cg  input  1  clock gate; state advances and i_strobe is sampled only when high.
REQ-006 SHALL have port i_strobe  input  1  single-cycle pulse from a strobe generator.
REQ-007 SHALL have port i_clear  input  1  synchronous clear of measurement state.
REQ-008 SHALL have port i_ready  input  1  consumer accepts measurement.
REQ-009 SHALL have port o_valid  output  1  measurement held in o_periodM1.
REQ-010 SHALL have port o_periodM1  output  CTRL_PERIOD_W  last measured period minus 1.
REQ-011 SHALL have port o_minPeriodM1 / o_maxPeriodM1  output  CTRL_PERIOD_W  extremes since clear.
REQ-012 SHALL have port o_nStrobes  output  CTRL_COUNT_W  saturating count of sampled strobes.
REQ-013 SHALL have port o_overflow / o_dropped  output  1 each  sticky error flags.

Function
REQ-014 SHALL implement FSM states IDLE (no strobe seen since reset/clear) and MEASURE.
REQ-015 SHALL, in IDLE, on a sampled strobe: zero the interval counter, go to MEASURE, emit no measurement.
REQ-016 SHALL, in MEASURE, increment the interval counter on each i_cg-high cycle without a strobe, saturating at all-ones and setting o_overflow on the saturating increment.
REQ-017 SHALL, in MEASURE, on a sampled strobe: capture the counter value as the measurement and zero the counter in the same cycle.
REQ-018 SHALL yield a measurement equal to the generator's period-minus-1 (strobes every P+1 enabled cycles -> P).
REQ-019 SHALL load o_periodM1 and assert o_valid one cycle after the capturing strobe.
REQ-020 SHALL deassert o_valid after a cycle with o_valid && i_ready, unless a new measurement loads that cycle.
REQ-021 SHALL, on a new measurement while o_valid && !i_ready, keep the old value and set sticky o_dropped.
REQ-022 SHALL, on a new measurement in the same cycle as o_valid && i_ready, load the new value with o_valid staying high and no drop.
REQ-023 SHALL update min/max with each captured value, including when dropped; min initialises to all-ones, max to zero.
REQ-024 SHALL increment o_nStrobes on every sampled strobe, in either state, saturating at all-ones.
REQ-025 SHALL ignore i_strobe, i_ready and i_clear while i_cg is low.
REQ-026 SHALL, on i_clear, return to IDLE and restore reset values of all outputs and counters; i_clear overrides a same-cycle strobe.

Reset
REQ-027 SHALL, while i_arst_n is low, force state IDLE, counter 0, o_valid 0, o_periodM1 0, o_minPeriodM1 all-ones, o_maxPeriodM1 0, o_nStrobes 0, o_overflow 0, o_dropped 0, regardless of i_cg.
REQ-028 SHALL, after reset mid-measurement, discard the partial interval and need two strobes before the next measurement.

Configuration
REQ-029 SHALL, with STROBE_METER_MINMAX_EN defined, implement min/max tracking per REQ-023.
REQ-030 SHALL, without STROBE_METER_MINMAX_EN, contain no min/max registers and tie o_minPeriodM1 to all-ones and o_maxPeriodM1 to zero; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover steady strobes every 5 cycles, i_ready=1: o_periodM1=4 each time, o_valid pulses one cycle per strobe, o_nStrobes counts all strobes.
REQ-032 SHALL cover gaps of 4, 6 and 5 cycles, with MINMAX_EN defined: o_periodM1 sequence 3, 5, 4; min=3; max=5.
REQ-033 SHALL cover i_ready=0 with two measurements arriving: first value held, o_dropped=1; i_ready=1 together with a third measurement: third value loaded, o_valid stays 1.
REQ-034 SHALL cover CTRL_PERIOD_W=4 with a 20-cycle gap: measurement 15, o_overflow=1.
REQ-035 SHALL cover i_clear asserted in the same cycle as a strobe mid-measurement: IDLE, all outputs at reset values, o_nStrobes=0.
REQ-036 SHALL cover i_cg low for 3 cycles inside a 5-enabled-cycle interval with a strobe pulsed while gated: strobe ignored, measurement=4.
